dcache_ctrl: RTL and testbench

Direct-mapped, write-through, no-write-allocate data cache controller between the datapath load/store port and the word-wide backing memory. It produces the MemHit, MemReadReady, MemReadDone, MemWriteReady and MemWriteDone status flags that the branch/jump next-PC stage samples to decide between holding and advancing the PC. Read hits complete in the request cycle. Misses and all writes stall the processor through a handshake with backing memory.

---
 rtl/cache_pkg.sv | 22 ++
 rtl/cache_array.sv | 44 ++++
 rtl/dcache_ctrl.sv | 133 +++++++++++++
 tb/tb_dcache_ctrl.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared types and defaults for the direct-mapped write-through data cache.
package cache_pkg;

  localparam int unsigned DEF_LINES = 16;
  localparam int unsigned TAG_MAX   = 30;

  typedef enum logic [2:0] {
    IDLE,
    RD_WAIT,
    RD_DONE,
    WR_WAIT,
    WR_DONE
  } state_t;

  // Tags are stored zero-extended to the widest possible tag so the struct is LINES-independent.
  typedef struct packed {
    logic               valid;
    logic [TAG_MAX-1:0] tag;
    logic [31:0]        data;
  } line_t;

endpackage

// File: rtl/cache_array.sv
// Valid/tag/data storage: combinational lookup port and one synchronous write port.
module cache_array
  import cache_pkg::*;
#(
  parameter int unsigned LINES = DEF_LINES,
  parameter int unsigned IDX_W = $clog2(LINES)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [IDX_W-1:0]   lk_idx,
  input  logic [TAG_MAX-1:0] lk_tag,
  output logic               hit,
  output logic [31:0]        data,
  input  logic               wr_en,
  input  logic [IDX_W-1:0]   wr_idx,
  input  line_t              wr_line
);

  logic [LINES-1:0]   valid_q;
  logic [TAG_MAX-1:0] tag_q  [LINES];
  logic [31:0]        data_q [LINES];

  // Only the valid bits need clearing; tag/data are don't-care while invalid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else if (wr_en) begin
      valid_q[wr_idx] <= wr_line.valid;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_q[wr_idx]  <= wr_line.tag;
      data_q[wr_idx] <= wr_line.data;
    end
  end

  always_comb begin
    hit  = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    data = data_q[lk_idx];
  end

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate data cache controller with a
// req/ack handshake to word-wide backing memory.
module dcache_ctrl
  import cache_pkg::*;
#(
  parameter int unsigned LINES = DEF_LINES,
  parameter int unsigned IDX_W = $clog2(LINES)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        MemHit,
  output logic        MemReadReady,
  output logic        MemReadDone,
  output logic        MemWriteReady,
  output logic        MemWriteDone,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  state_t      state, next_state;
  logic [29:0] lk_word;
  logic        lk_hit;
  logic [31:0] lk_data;
  logic        wr_en;
  line_t       wr_line;
  logic        rd_hit_c;
  logic [31:0] cap_data;

  // In IDLE the lookup follows the live request; otherwise the latched address.
  always_comb begin
    lk_word = (state == IDLE) ? addr[31:2] : mem_addr[31:2];
  end

  cache_array #(
    .LINES (LINES),
    .IDX_W (IDX_W)
  ) u_array (
    .clk     (clk),
    .rst_n   (rst_n),
    .lk_idx  (lk_word[IDX_W-1:0]),
    .lk_tag  (TAG_MAX'(lk_word[29:IDX_W])),
    .hit     (lk_hit),
    .data    (lk_data),
    .wr_en   (wr_en),
    .wr_idx  (mem_addr[IDX_W+1:2]),
    .wr_line (wr_line)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    wr_en      = 1'b0;
    wr_line    = '0;
    rd_hit_c   = 1'b0;
    unique case (state)
      IDLE: begin
        if (MemWrite) begin
          next_state = WR_WAIT;
        end else if (MemRead) begin
          if (lk_hit) rd_hit_c = 1'b1;
          else        next_state = RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (mem_ack) begin
          wr_en      = 1'b1;
          wr_line    = '{valid: 1'b1, tag: TAG_MAX'(mem_addr[31:IDX_W+2]), data: mem_rdata};
          next_state = RD_DONE;
        end
      end
      RD_DONE: next_state = IDLE;
      WR_WAIT: begin
        if (mem_ack) begin
          // Write-through: refresh only a resident line, never allocate.
          wr_en      = lk_hit;
          wr_line    = '{valid: 1'b1, tag: TAG_MAX'(mem_addr[31:IDX_W+2]), data: mem_wdata};
          next_state = WR_DONE;
        end
      end
      WR_DONE: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    MemHit = rd_hit_c || (state == RD_DONE);
    rdata  = '0;
    if (rd_hit_c)               rdata = lk_data;
    else if (state == RD_DONE)  rdata = cap_data;
  end

  // Status flags and memory handshake are registered from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      MemReadReady  <= 1'b0;
      MemReadDone   <= 1'b0;
      MemWriteReady <= 1'b0;
      MemWriteDone  <= 1'b0;
      mem_req       <= 1'b0;
      mem_we        <= 1'b0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
      cap_data      <= '0;
    end else begin
      MemReadReady  <= (next_state == RD_WAIT);
      MemReadDone   <= (next_state == RD_DONE);
      MemWriteReady <= (next_state == WR_WAIT);
      MemWriteDone  <= (next_state == WR_DONE);
      mem_req       <= (next_state == RD_WAIT) || (next_state == WR_WAIT);
      mem_we        <= (next_state == WR_WAIT);
      if (state == IDLE && next_state != IDLE) mem_addr <= addr & 32'hFFFF_FFFC;
      if (state == IDLE && MemWrite)           mem_wdata <= wdata;
      if (state == RD_WAIT && mem_ack)         cap_data <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Self-checking bench for dcache_ctrl: directed vector table, hand-written corner
// sequences and randomized accesses against an operation-level cache model.
module tb_dcache_ctrl;

  localparam int unsigned LINES = 16;
  localparam int unsigned IDX_W = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        MemRead = 1'b0;
  logic        MemWrite = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic [31:0] rdata;
  logic        MemHit, MemReadReady, MemReadDone, MemWriteReady, MemWriteDone;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;

  dcache_ctrl dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .MemRead       (MemRead),
    .MemWrite      (MemWrite),
    .addr          (addr),
    .wdata         (wdata),
    .rdata         (rdata),
    .MemHit        (MemHit),
    .MemReadReady  (MemReadReady),
    .MemReadDone   (MemReadDone),
    .MemWriteReady (MemWriteReady),
    .MemWriteDone  (MemWriteDone),
    .mem_req       (mem_req),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_ack       (mem_ack),
    .mem_rdata     (mem_rdata)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one word per line, backing memory as a sparse word array.
  bit          m_valid [LINES];
  logic [31:0] m_word  [LINES];
  logic [31:0] m_data  [LINES];
  logic [31:0] memory  [int unsigned];

  task automatic m_read(input logic [31:0] a, output bit h, output logic [31:0] d);
    int unsigned w = a >> 2;
    int unsigned i = w % LINES;
    if (m_valid[i] && m_word[i] == w) begin
      h = 1'b1;
      d = m_data[i];
    end else begin
      h = 1'b0;
      if (!memory.exists(w)) memory[w] = $urandom;
      d = memory[w];
      m_valid[i] = 1'b1;
      m_word[i]  = w;
      m_data[i]  = d;
    end
  endtask

  task automatic m_write(input logic [31:0] a, input logic [31:0] d);
    int unsigned w = a >> 2;
    int unsigned i = w % LINES;
    memory[w] = d;
    if (m_valid[i] && m_word[i] == w) m_data[i] = d;
  endtask

  task automatic m_flush();
    for (int i = 0; i < LINES; i++) m_valid[i] = 1'b0;
  endtask

  // Runs one access starting at posedge+1 of an IDLE cycle; returns at posedge+1 of the next IDLE.
  task automatic do_access(input bit wr, input bit also_rd, input logic [31:0] a,
                           input logic [31:0] d, input int lat, input bit exp_hit,
                           input logic [31:0] exp_rd);
    logic [31:0] wa = a & 32'hFFFF_FFFC;
    MemWrite = wr;
    MemRead  = !wr || also_rd;
    addr     = a;
    wdata    = d;
    mem_ack  = 1'b0;
    #4;
    chk("detect_hit", MemHit, wr ? 1'b0 : exp_hit);
    chk("detect_req", mem_req, 1'b0);
    if (!wr && exp_hit) begin
      chk("hit_rdata", rdata, exp_rd);
      @(posedge clk); #1;
      MemRead = 1'b0;
      return;
    end
    for (int c = 1; c <= lat; c++) begin
      @(posedge clk); #1;
      addr  = $urandom;
      wdata = $urandom;
      if (c == lat) begin
        mem_ack   = 1'b1;
        mem_rdata = wr ? $urandom : d;
      end
      #4;
      chk("wait_req", mem_req, 1'b1);
      chk("wait_we", mem_we, wr);
      chk("wait_addr", mem_addr, wa);
      chk("wait_flags", {MemReadReady, MemReadDone, MemWriteReady, MemWriteDone, MemHit},
          wr ? 5'b00100 : 5'b10000);
      if (wr) chk("wait_wdata", mem_wdata, d);
    end
    @(posedge clk); #1;
    mem_ack   = 1'b0;
    mem_rdata = $urandom;
    #4;
    chk("done_req", mem_req, 1'b0);
    chk("done_flags", {MemReadReady, MemReadDone, MemWriteReady, MemWriteDone, MemHit},
        wr ? 5'b00010 : 5'b01001);
    if (!wr) chk("done_rdata", rdata, exp_rd);
    @(posedge clk); #1;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
  endtask

  task automatic idle_cycle(input bit ack);
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    mem_ack  = ack;
    #4;
    chk("idle_flags", {mem_req, MemReadReady, MemReadDone, MemWriteReady, MemWriteDone, MemHit}, 6'b0);
    @(posedge clk); #1;
    mem_ack = 1'b0;
  endtask

  typedef struct {
    bit          wr;
    logic [31:0] a;
    logic [31:0] d;
    int          lat;
    bit          exp_hit;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t tbl [12];

  initial begin
    bit          h;
    logic [31:0] dd;

    tbl[0]  = '{1'b0, 32'h40,  32'hDEADBEEF, 3, 1'b0, 32'hDEADBEEF};
    tbl[1]  = '{1'b0, 32'h40,  32'h0,        0, 1'b1, 32'hDEADBEEF};
    tbl[2]  = '{1'b0, 32'h80,  32'hCAFEF00D, 2, 1'b0, 32'hCAFEF00D};
    tbl[3]  = '{1'b1, 32'h80,  32'h12345678, 2, 1'b0, 32'h0};
    tbl[4]  = '{1'b0, 32'h80,  32'h0,        0, 1'b1, 32'h12345678};
    tbl[5]  = '{1'b0, 32'h40,  32'hDEADBEEF, 1, 1'b0, 32'hDEADBEEF};
    tbl[6]  = '{1'b1, 32'h100, 32'hA5A5A5A5, 1, 1'b0, 32'h0};
    tbl[7]  = '{1'b0, 32'h40,  32'h0,        0, 1'b1, 32'hDEADBEEF};
    tbl[8]  = '{1'b0, 32'h100, 32'hA5A5A5A5, 2, 1'b0, 32'hA5A5A5A5};
    tbl[9]  = '{1'b0, 32'h44,  32'h11112222, 1, 1'b0, 32'h11112222};
    tbl[10] = '{1'b1, 32'h47,  32'h55AA55AA, 3, 1'b0, 32'h0};
    tbl[11] = '{1'b0, 32'h46,  32'h0,        0, 1'b1, 32'h55AA55AA};
    m_flush();

    // Reset values
    #7;
    chk("rst_flags", {MemHit, MemReadReady, MemReadDone, MemWriteReady, MemWriteDone, mem_req, mem_we}, 7'b0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int n = 0; n < 12; n++) begin
      if (tbl[n].wr) begin
        m_write(tbl[n].a, tbl[n].d);
      end else begin
        if (!tbl[n].exp_hit) memory[tbl[n].a >> 2] = tbl[n].d;
        m_read(tbl[n].a, h, dd);
      end
      do_access(tbl[n].wr, 1'b0, tbl[n].a, tbl[n].d, tbl[n].lat, tbl[n].exp_hit, tbl[n].exp_rd);
    end

    // mem_ack while idle must be ignored
    idle_cycle(1'b1);
    do_access(1'b0, 1'b0, 32'h46, 32'h0, 0, 1'b1, 32'h55AA55AA);

    // Asynchronous reset in the middle of a read miss
    MemRead = 1'b1;
    addr    = 32'h200;
    #4;
    chk("rstmid_detect_hit", MemHit, 1'b0);
    @(posedge clk); #1;
    #4;
    chk("rstmid_req_before", mem_req, 1'b1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rstmid_req_async", mem_req, 1'b0);
    chk("rstmid_ready_async", MemReadReady, 1'b0);
    @(posedge clk); #1;
    rst_n   = 1'b1;
    MemRead = 1'b0;
    m_flush();
    @(posedge clk); #1;
    m_read(32'h40, h, dd);
    do_access(1'b0, 1'b0, 32'h40, dd, 2, h, dd);

    // MemWrite wins over a simultaneous MemRead that would hit
    m_write(32'h40, 32'h77778888);
    do_access(1'b1, 1'b1, 32'h40, 32'h77778888, 2, 1'b0, 32'h0);
    m_read(32'h40, h, dd);
    do_access(1'b0, 1'b0, 32'h40, dd, 1, h, dd);

    for (int n = 0; n < 150; n++) begin
      logic [31:0] a;
      logic [31:0] d;
      int          lat;
      bit          wr;
      a   = 32'($urandom_range(0, 255));
      lat = $urandom_range(1, 4);
      wr  = ($urandom_range(0, 9) < 3);
      if (wr) begin
        d = $urandom;
        m_write(a, d);
        do_access(1'b1, 1'($urandom_range(0, 1)), a, d, lat, 1'b0, 32'h0);
      end else begin
        m_read(a, h, dd);
        do_access(1'b0, 1'b0, a, dd, lat, h, dd);
      end
      if ($urandom_range(0, 4) == 0) idle_cycle(1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
